output_port_allocator: RTL
==========================

OUTPUT_PORT_ALLOCATOR -- requirements
Module: output_port_allocator

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 5: number of requesting router input ports.
REQ-002 SHALL have parameter FLIT_BUFFER_DEPTH, default 1: downstream buffer depth, which is also the initial credit count.
REQ-003 SHALL have localparam CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH+1).
REQ-004 SHALL use one clock and a synchronous, active-low reset (Already decided): clk  input  1  NoC clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port req  input  NUM_INPUTS  per-input request for this output, asserted while a head-of-queue flit targets it.
REQ-007 SHALL have port req_is_tail  input  NUM_INPUTS  tail flag of each requester's current flit.
REQ-008 SHALL have port turn_disable  input  NUM_INPUTS  per-input mask; when set, new packets from that input are not eligible.
REQ-009 SHALL have port grant  output  NUM_INPUTS  one-hot or zero; flit of the granted input transfers this cycle.
REQ-010 SHALL have port send_out  output  1  equals OR of grant; this is the flit-valid toward downstream.
REQ-011 SHALL have port credit_in  input  1  one downstream buffer slot freed.
REQ-012 SHALL have port credit_count  output  CREDIT_WIDTH  current available credits.
REQ-013 SHALL have port locked  output  1  a packet owns the output.
REQ-014 SHALL have port credit_overflow  output  1  sticky error flag.

Function
REQ-015 grant SHALL be combinational from req, req_is_tail, turn_disable and registered state, giving zero-cycle arbitration latency.
REQ-016 No grant SHALL be issued when credit_count == 0.
REQ-017 When unlocked, eligible = req & ~turn_disable; the winner SHALL be the first eligible index at or after rr_ptr, searching cyclically with wrap from NUM_INPUTS-1 to 0.
REQ-018 When locked, grant SHALL go only to owner, and only if req[owner] and credit_count > 0; turn_disable is ignored while locked.
REQ-019 On a granted non-tail flit while unlocked, the block SHALL set locked=1 and owner=winner.
REQ-020 On a granted tail flit, the block SHALL clear locked and set rr_ptr = (granted index + 1) mod NUM_INPUTS; single-flit packets never lock.
REQ-021 If the owner drops req while locked, the lock SHALL hold and grant SHALL be 0 until the owner resumes.
REQ-022 Credit update rules: send_out alone gives count-1; credit_in alone gives count+1; both together leave count unchanged.
REQ-023 A credit_in arriving with count == FLIT_BUFFER_DEPTH and no send SHALL saturate the count and set credit_overflow, which holds until reset.
REQ-024 rr_ptr SHALL change only on tail grants; a FSM of IDLE and LOCKED is encoded by the locked bit.

Reset
REQ-025 While rst_n==0 at a clock edge, the block SHALL set credit_count=FLIT_BUFFER_DEPTH, locked=0, owner=0, rr_ptr=0, credit_overflow=0.
REQ-026 grant and send_out SHALL be forced to 0 while rst_n==0.
REQ-027 A reset asserted mid-packet SHALL drop the lock without emitting any further grant.

Structure
REQ-028 NUM_INPUTS default and port-index constants (LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4) SHALL live in the shared router package.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: eligible vector and pointer; output: one-hot winner), reusable per output port.
REQ-030 One output_port_allocator instance SHALL exist per router output.

Verification
REQ-031 Reset with depth 2, then req=5'b00110 with all tails -> cycle 1 grants input 1, cycle 2 grants input 2 (credit reaches 0), no grant until credit_in.
REQ-032 Input 3 sends a 3-flit packet (tail on the third flit) while input 1 also requests -> grants 3,3,3 consecutively, then input 1; locked is high for two cycles.
REQ-033 Locked owner drops req for 2 cycles while input 0 requests -> grant=0 for those cycles, then the owner resumes.
REQ-034 credit_count=0 with credit_in and a pending request in the same cycle -> no grant that cycle, count becomes 1, grant next cycle.
REQ-035 Depth 1 at full: send and credit_in together -> count stays 1; credit_in alone at full -> credit_overflow=1 and count remains 1.
REQ-036 turn_disable[2]=1 with req=5'b00100 -> no grant; set turn_disable[2] mid-packet of input 2 -> the packet completes.

Source files
------------

// File: rtl/output_port_allocator_pkg.sv
// Shared router definitions: port count, port index constants and the
// output allocator state type.
package output_port_allocator_pkg;

  localparam int unsigned NUM_INPUTS_DEFAULT = 5;

  localparam int unsigned PORT_LOCAL = 0;
  localparam int unsigned PORT_NORTH = 1;
  localparam int unsigned PORT_SOUTH = 2;
  localparam int unsigned PORT_EAST  = 3;
  localparam int unsigned PORT_WEST  = 4;

  // Encoded by a single bit so that the locked output is the state itself.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_port_allocator_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr,
// wrapping from NUM_INPUTS-1 back to 0.
module rr_arbiter #(
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned PTR_WIDTH  = 3
) (
  input  logic [NUM_INPUTS-1:0] eligible,
  input  logic [PTR_WIDTH-1:0]  rr_ptr,
  output logic [NUM_INPUTS-1:0] winner
);

  logic                 found;
  logic [PTR_WIDTH-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      idx = PTR_WIDTH'((32'(rr_ptr) + k) % NUM_INPUTS);
      if (!found && eligible[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output switch allocator: round-robin packet arbitration with wormhole
// locking and credit-based flow control toward the downstream buffer.
module output_port_allocator
  import output_port_allocator_pkg::*;
#(
  parameter  int unsigned NUM_INPUTS        = NUM_INPUTS_DEFAULT,
  parameter  int unsigned FLIT_BUFFER_DEPTH = 1,
  localparam int unsigned CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_INPUTS-1:0]   req,
  input  logic [NUM_INPUTS-1:0]   req_is_tail,
  input  logic [NUM_INPUTS-1:0]   turn_disable,
  output logic [NUM_INPUTS-1:0]   grant,
  output logic                    send_out,
  input  logic                    credit_in,
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    locked,
  output logic                    credit_overflow
);

  localparam int unsigned          PTR_WIDTH = ptr_width(NUM_INPUTS);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [PTR_WIDTH-1:0]    LAST_IDX    = PTR_WIDTH'(NUM_INPUTS - 1);

  alloc_state_e              state_q, state_d;
  logic [PTR_WIDTH-1:0]      owner_q, owner_d;
  logic [PTR_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CREDIT_WIDTH-1:0]   credit_q, credit_d;
  logic                      overflow_q, overflow_d;
  logic [NUM_INPUTS-1:0]     eligible, arb_winner;
  logic [PTR_WIDTH-1:0]      grant_idx;
  logic                      grant_tail;

  assign eligible = req & ~turn_disable;

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_rr_arbiter (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .winner   (arb_winner)
  );

  // Gating on rst_n keeps a mid-packet reset from leaking a final grant.
  always_comb begin
    grant = '0;
    if (rst_n && (credit_q != '0)) begin
      if (state_q == ST_LOCKED) grant[owner_q] = req[owner_q];
      else                      grant = arb_winner;
    end
  end

  assign send_out = |grant;

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) grant_idx = PTR_WIDTH'(i);
    end
    grant_tail = |(grant & req_is_tail);
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    credit_d   = credit_q;
    overflow_d = overflow_q;

    if (send_out) begin
      if (grant_tail) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_WIDTH'(1);
      end else if (state_q == ST_IDLE) begin
        state_d = ST_LOCKED;
        owner_d = grant_idx;
      end
    end

    case ({send_out, credit_in})
      2'b10: credit_d = credit_q - CREDIT_WIDTH'(1);
      2'b01: begin
        if (credit_q == CREDIT_FULL) overflow_d = 1'b1;
        else                         credit_d   = credit_q + CREDIT_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      credit_q   <= CREDIT_FULL;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  assign locked          = (state_q == ST_LOCKED);
  assign credit_count    = credit_q;
  assign credit_overflow = overflow_q;

endmodule
